// File: rtl/aes_hex_pager.sv
// Paged 7-segment front-end for a buffered AES cipher block.
// One 32-bit word is shown at a time; paging advances on a prescaler tick or a manual step.
module aes_hex_pager #(
  parameter int unsigned DIV_W      = 23,
  parameter int unsigned WORDS      = 4,
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned ACTIVE_LOW = 1,
  localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_data,
  input  logic                  auto_mode,
  input  logic                  step,
  output logic [7*DIGITS-1:0]   hex,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  busy,
  output logic                  tick
);

  localparam logic [6:0]          BLANK     = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [7*DIGITS-1:0] BLANK_ALL = {DIGITS{BLANK}};
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, PAGE, DONE} state_t;

  state_t                    state;
  logic [WORDS-1:0][31:0]    blk_q;
  logic [IDX_W-1:0]          idx_q;
  logic [DIV_W-1:0]          cnt_q;
  logic [31:0]               word_c;
  logic [7*DIGITS-1:0]       glyphs_c;
  logic                      adv_c;

  // Standard hex glyphs, gfedcba, stored in active-low form.
  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'h40;
      4'h1: c = 7'h79;
      4'h2: c = 7'h24;
      4'h3: c = 7'h30;
      4'h4: c = 7'h19;
      4'h5: c = 7'h12;
      4'h6: c = 7'h02;
      4'h7: c = 7'h78;
      4'h8: c = 7'h00;
      4'h9: c = 7'h10;
      4'hA: c = 7'h08;
      4'hB: c = 7'h03;
      4'hC: c = 7'h46;
      4'hD: c = 7'h21;
      4'hE: c = 7'h06;
      4'hF: c = 7'h0E;
      default: c = 7'h7F;
    endcase
    return (ACTIVE_LOW != 0) ? c : ~c;
  endfunction

  // Decode the currently selected word, one nibble per digit.
  always_comb begin
    word_c   = blk_q[idx_q];
    glyphs_c = BLANK_ALL;
    for (int k = 0; k < int'(DIGITS); k++) begin
      glyphs_c[7*k +: 7] = seg(word_c[4*k +: 4]);
    end
    adv_c = (auto_mode & tick) | (~auto_mode & step);
  end

  // Display and word_idx lag the internal index by one cycle so they update together.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      tick     <= 1'b0;
      word_idx <= '0;
      hex      <= BLANK_ALL;
      blk_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      word_idx <= idx_q;
      hex      <= (state == IDLE) ? BLANK_ALL : glyphs_c;
      tick     <= (state == PAGE) && (cnt_q == '1);
      case (state)
        IDLE, DONE: begin
          if (in_valid) begin
            blk_q    <= in_data;
            idx_q    <= '0;
            cnt_q    <= '0;
            state    <= PAGE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        PAGE: begin
          cnt_q <= cnt_q + DIV_W'(1);
          if (adv_c) begin
            if (idx_q != LAST_IDX) begin
              idx_q <= idx_q + IDX_W'(1);
            end else begin
              state    <= DONE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_hex_pager.sv
// Randomized self-checking bench for aes_hex_pager against a cycle-level transaction model.
module tb_aes_hex_pager;

  localparam int DIV_W  = 4;
  localparam int WORDS  = 4;
  localparam int DIGITS = 8;
  localparam int IDX_W  = 2;
  localparam int PERIOD = 1 << DIV_W;
  localparam logic [7*DIGITS-1:0] BLANK_ALL = {DIGITS{7'h7F}};

  logic                  CLOCK_50 = 1'b0;
  logic                  resetn   = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [32*WORDS-1:0]   in_data  = '0;
  logic                  auto_mode = 1'b0;
  logic                  step     = 1'b0;
  logic [7*DIGITS-1:0]   hex;
  logic [IDX_W-1:0]      word_idx;
  logic                  busy;
  logic                  tick;

  aes_hex_pager #(.DIV_W(DIV_W), .WORDS(WORDS), .DIGITS(DIGITS), .ACTIVE_LOW(1)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .auto_mode(auto_mode),
    .step     (step),
    .hex      (hex),
    .word_idx (word_idx),
    .busy     (busy),
    .tick     (tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: glyph table, buffered block, paging status and a count of cycles since accept.
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] m_blk [WORDS];
  int          m_idx, m_widx, m_n;
  bit          m_paging, m_done, m_tick;
  logic [7*DIGITS-1:0] m_hex;

  function automatic logic [7*DIGITS-1:0] show(input logic [31:0] w);
    logic [7*DIGITS-1:0] r;
    logic [3:0] nib;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = w[4*k +: 4];
      r[7*k +: 7] = glyph[nib];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < WORDS; w++) m_blk[w] = '0;
    m_idx = 0; m_widx = 0; m_n = 0;
    m_paging = 0; m_done = 0; m_tick = 0;
    m_hex = BLANK_ALL;
  endtask

  task automatic model_step();
    bit adv, nt;
    logic [7*DIGITS-1:0] nh;
    int nw;
    adv = m_paging && (auto_mode ? m_tick : step);
    nh  = (m_paging || m_done) ? show(m_blk[m_idx]) : BLANK_ALL;
    nw  = m_idx;
    nt  = m_paging && ((m_n % PERIOD) == PERIOD - 1);
    if (!m_paging && in_valid) begin
      for (int w = 0; w < WORDS; w++) m_blk[w] = in_data[32*w +: 32];
      m_idx = 0; m_n = 0; m_paging = 1; m_done = 0;
    end else if (m_paging) begin
      m_n++;
      if (adv) begin
        if (m_idx < WORDS - 1) m_idx++;
        else begin m_paging = 0; m_done = 1; end
      end
    end
    m_hex = nh; m_widx = nw; m_tick = nt;
  endtask

  task automatic compare(input string ph);
    check({ph, ".in_ready"}, 64'(in_ready), 64'(!m_paging));
    check({ph, ".busy"},     64'(busy),     64'(m_paging));
    check({ph, ".tick"},     64'(tick),     64'(m_tick));
    check({ph, ".word_idx"}, 64'(word_idx), 64'(m_widx));
    check({ph, ".hex"},      64'(hex),      64'(m_hex));
  endtask

  task automatic cyc(input string ph);
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    compare(ph);
  endtask

  task automatic check_reset_values(input string ph);
    check({ph, ".in_ready"}, 64'(in_ready), 64'd1);
    check({ph, ".busy"},     64'(busy),     64'd0);
    check({ph, ".tick"},     64'(tick),     64'd0);
    check({ph, ".word_idx"}, 64'(word_idx), 64'd0);
    check({ph, ".hex"},      64'(hex),      64'(BLANK_ALL));
  endtask

  // Called at a falling edge: assert reset between edges, check, release at next falling edge.
  task automatic async_reset(input string ph);
    #2 resetn = 1'b0;
    #1 model_reset();
    check_reset_values(ph);
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  function automatic logic [32*WORDS-1:0] rand_block();
    logic [32*WORDS-1:0] b;
    for (int w = 0; w < WORDS; w++) b[32*w +: 32] = $urandom;
    return b;
  endfunction

  task automatic wait_done(input string ph);
    int t;
    t = 0;
    while (!m_done && t < 200) begin cyc(ph); t++; end
    if (!m_done) check({ph, ".done_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int t, last, chg;
    logic [IDX_W-1:0] prev;
    logic [32*WORDS-1:0] blk;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    check_reset_values("rst");
    resetn = 1'b1;

    repeat (10) cyc("t1");
    check_reset_values("t1");

    // Auto paging of a directed block.
    auto_mode = 1'b1;
    in_data   = {32'h33333333, 32'h22222222, 32'h11111111, 32'h0123ABCF};
    in_valid  = 1'b1;
    cyc("t2");
    in_valid  = 1'b0;
    cyc("t2");
    check("t2.word0", 64'(hex), 64'(show(32'h0123ABCF)));
    t = 0; last = 0; chg = 0; prev = word_idx;
    while (!m_done && t < 200) begin
      cyc("t2"); t++;
      if (word_idx != prev) begin
        if (chg > 0) check("t2.period", 64'(t - last), 64'(PERIOD));
        last = t; chg++; prev = word_idx;
      end
    end
    if (!m_done) check("t2.done_timeout", 64'd0, 64'd1);
    cyc("t2");
    check("t2.last_hex", 64'(hex), 64'({DIGITS{7'h30}}));
    check("t2.ready", 64'(in_ready), 64'd1);

    // Manual paging: nothing moves without step.
    auto_mode = 1'b0;
    in_data   = rand_block();
    in_valid  = 1'b1;
    cyc("t3");
    in_valid  = 1'b0;
    repeat (40) cyc("t3");
    check("t3.hold", 64'(word_idx), 64'd0);
    repeat (4) cyc("t3");
    step = 1'b1;
    cyc("t3"); cyc("t3");
    step = 1'b0;
    cyc("t3"); cyc("t3");
    check("t3.two_steps", 64'(word_idx), 64'd2);

    // Auto mode: step coinciding with tick gives one advance; in_valid ignored while paging.
    auto_mode = 1'b1;
    in_data   = rand_block();
    in_valid  = 1'b1;
    t = 0;
    while (!m_tick && t < 64) begin cyc("t4"); t++; end
    if (!m_tick) check("t4.tick_timeout", 64'd0, 64'd1);
    step = 1'b1;
    cyc("t4");
    step = 1'b0;
    cyc("t4");
    check("t4.single", 64'(word_idx), 64'd3);
    check("t4.no_capture", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_done("t4");

    // Asynchronous reset mid-page, then a fresh accept from IDLE.
    in_data  = rand_block();
    in_valid = 1'b1;
    cyc("t5");
    in_valid = 1'b0;
    t = 0;
    while (m_widx != 2 && t < 100) begin cyc("t5"); t++; end
    check("t5.reached_idx2", 64'(word_idx), 64'd2);
    async_reset("t5.rst");
    blk      = rand_block();
    in_data  = blk;
    in_valid = 1'b1;
    cyc("t5");
    in_valid = 1'b0;
    cyc("t5");
    check("t5.word0", 64'(hex), 64'(show(blk[31:0])));

    // Accept straight out of DONE; prescaler restarts from zero.
    wait_done("t6");
    blk      = rand_block();
    in_data  = blk;
    in_valid = 1'b1;
    check("t6.ready", 64'(in_ready), 64'd1);
    cyc("t6");
    in_valid = 1'b0;
    cyc("t6");
    check("t6.word0", 64'(hex), 64'(show(blk[31:0])));
    check("t6.idx0", 64'(word_idx), 64'd0);
    t = 0;
    while (word_idx == 0 && t < 100) begin cyc("t6"); t++; end
    check("t6.restart", 64'(t), 64'(PERIOD + 1));

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      step     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) auto_mode = ~auto_mode;
      in_data  = rand_block();
      if ($urandom_range(0, 399) == 0) async_reset("rnd.rst");
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
